// File: rtl/arc4_pkg.sv
// ---------------------------------------------------------------------------
// arc4_pkg
//  Shared types and constants for the ARC4 datapath stages (init, ksa, prga,
//  prga_encrypt). Holds the byte type, the S memory geometry, the address of
//  the length byte in the message memories and the PRGA state encoding.
// ---------------------------------------------------------------------------
package arc4_pkg;

    typedef logic [7:0] byte_t;

    // S memory depth (byte wide)
    localparam int S_SIZE = 256;

    // Cycles spent in the byte loop for every message byte
    localparam int STEP_CYC = 9;

    // Messages are length-prefixed: byte 0 holds the length
    localparam byte_t LEN_ADDR = 8'h00;

    typedef enum logic [3:0] {
        IDLE,
        LEN_RD,
        LEN_WAIT,
        LEN_WR,
        SI_RD,
        SI_WAIT,
        SJ_RD,
        SJ_WAIT,
        SW_I,
        SW_J,
        PAD_RD,
        PAD_WAIT,
        CT_WR
    } prga_state_t;

endpackage

// File: rtl/prga_encrypt.sv
// ---------------------------------------------------------------------------
// prga_encrypt
//  Encrypt direction of the ARC4 datapath. Reads a length-prefixed plaintext
//  message from PT memory, runs the ARC4 keystream generator over an already
//  key-scheduled S memory and writes the length-prefixed ciphertext to CT
//  memory. Each message byte takes a fixed nine cycles.
//
// Ports
//  clk        in   single clock, all state on the rising edge
//  rst_n      in   asynchronous, active-low reset
//  en         in   start request, sampled only while rdy=1
//  rdy        out  1 = idle, can accept en
//  s_addr     out  S memory address
//  s_rddata   in   S memory read data (1-cycle synchronous read)
//  s_wrdata   out  S memory write data
//  s_wren     out  S memory write enable
//  pt_addr    out  plaintext memory address (read only)
//  pt_rddata  in   plaintext read data (1-cycle synchronous read)
//  ct_addr    out  ciphertext memory address
//  ct_wrdata  out  ciphertext write data
//  ct_wren    out  ciphertext write enable
// ---------------------------------------------------------------------------
module prga_encrypt
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic [7:0] ct_addr,
    output logic [7:0] ct_wrdata,
    output logic       ct_wren
);

    prga_state_t state;
    prga_state_t state_next;

    byte_t i;
    byte_t j;
    byte_t k;
    byte_t msg_len;
    byte_t si;
    byte_t sj;
    byte_t pad;
    byte_t ptb;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. i and j restart at zero on every accepted start so
    // a second run on an unrekeyed S simply continues from a permuted table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i       <= '0;
            j       <= '0;
            k       <= '0;
            msg_len <= '0;
            si      <= '0;
            sj      <= '0;
            pad     <= '0;
            ptb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                LEN_WAIT: begin
                    msg_len <= pt_rddata;
                end
                LEN_WR: begin
                    k <= 8'd1;
                end
                SI_RD: begin
                    i <= i + 8'd1;
                end
                SI_WAIT: begin
                    si <= s_rddata;
                    j  <= j + s_rddata;
                end
                SJ_WAIT: begin
                    sj <= s_rddata;
                end
                PAD_WAIT: begin
                    pad <= s_rddata;
                    ptb <= pt_rddata;
                end
                CT_WR: begin
                    if (k != msg_len) begin
                        k <= k + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and memory interface. Every output defaults to zero, so in
    // IDLE (and straight after reset) all addresses and enables are quiet.
    // When i==j the two swap writes hit the same address with the same byte,
    // leaving S unchanged without any special handling.
    always_comb begin
        state_next = state;
        rdy        = 1'b0;
        s_addr     = '0;
        s_wrdata   = '0;
        s_wren     = 1'b0;
        pt_addr    = '0;
        ct_addr    = '0;
        ct_wrdata  = '0;
        ct_wren    = 1'b0;

        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    state_next = LEN_RD;
                end
            end
            LEN_RD: begin
                pt_addr    = LEN_ADDR;
                state_next = LEN_WAIT;
            end
            LEN_WAIT: begin
                state_next = LEN_WR;
            end
            LEN_WR: begin
                ct_addr    = LEN_ADDR;
                ct_wrdata  = msg_len;
                ct_wren    = 1'b1;
                state_next = (msg_len == 8'd0) ? IDLE : SI_RD;
            end
            SI_RD: begin
                // i is incremented in this same cycle, so address with i+1
                s_addr     = i + 8'd1;
                state_next = SI_WAIT;
            end
            SI_WAIT: begin
                state_next = SJ_RD;
            end
            SJ_RD: begin
                s_addr     = j;
                state_next = SJ_WAIT;
            end
            SJ_WAIT: begin
                state_next = SW_I;
            end
            SW_I: begin
                s_addr     = i;
                s_wrdata   = sj;
                s_wren     = 1'b1;
                state_next = SW_J;
            end
            SW_J: begin
                s_addr     = j;
                s_wrdata   = si;
                s_wren     = 1'b1;
                state_next = PAD_RD;
            end
            PAD_RD: begin
                s_addr     = si + sj;
                pt_addr    = k;
                state_next = PAD_WAIT;
            end
            PAD_WAIT: begin
                state_next = CT_WR;
            end
            CT_WR: begin
                ct_addr    = k;
                ct_wrdata  = pad ^ ptb;
                ct_wren    = 1'b1;
                state_next = (k == msg_len) ? IDLE : SI_RD;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
